pipe_hazard_ctrl: RTL and testbench
===================================

Name: pipe_hazard_ctrl

Overview:
- Central stall/flush controller for the 5-stage pipelined MIPS core.
- Drives the PC unit's PCWrite enable and the IF/ID and ID/EX pipeline-register controls.
- Resolves load-use hazards and branch-in-ID operand hazards, freezes the pipeline on Avalon waitrequest, and sequences end-of-program drain/halt once the PC reaches 0.

Parameters:
- DRAIN_CYCLES, 4, unfrozen cycles between PC reaching 0 and active deasserting.
- CNT_W, 32, width of optional performance counters.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- IF_ID_Instruction  in  32  instruction currently in ID
- RegPC  in  32  current PC from the PC unit
- ID_EX_MemRead  in  1  instruction in EX is a load
- ID_EX_RegWrite  in  1  instruction in EX writes a GPR
- ID_EX_WriteReg  in  5  destination register of the EX instruction
- EX_MEM_MemRead  in  1  instruction in MEM is a load
- EX_MEM_WriteReg  in  5  destination register of the MEM instruction
- instr_waitrequest  in  1  instruction bus stall
- data_waitrequest  in  1  data bus stall (valid only while MEM accesses memory)
- PCWrite  out  1  PC update enable
- IF_ID_Write  out  1  IF/ID register load enable
- IF_ID_Flush  out  1  load NOP into IF/ID
- ID_EX_Flush  out  1  load bubble into ID/EX
- Pipe_Write  out  1  EX/MEM and MEM/WB load enable
- active  out  1  CPU running
- stall_cycles  out  CNT_W  hazard-bubble count (0 when the feature is off)
- cycle_count  out  CNT_W  unfrozen cycle count (0 when the feature is off)

Behaviour:
- Reset: synchronous, active-high.
  - While reset is high: PCWrite=1, IF_ID_Write=1, IF_ID_Flush=1, ID_EX_Flush=1, Pipe_Write=1, active=0.
  - After reset: state=RUN, drain counter=0, active=1 from the first cycle after reset is released.
- Decode of IF_ID_Instruction:
  - rs=[25:21], rt=[20:16].
  - uses_rs: all opcodes except J (000010) and JAL (000011).
  - uses_rt: R-type (except JR/JALR), BEQ/BNE, and stores (101xxx).
  - branch_id: opcodes 000100, 000101, 000110, 000111, 000001, or R-type with funct 001000/001001.
- match(r): r!=0 and ((uses_rs and rs==r) or (uses_rt and rt==r)). Register 0 never causes a hazard.
- Hazard (combinational), either condition:
  - (ID_EX_MemRead or (branch_id and ID_EX_RegWrite)) and match(ID_EX_WriteReg)
  - branch_id and EX_MEM_MemRead and match(EX_MEM_WriteReg)
- freeze = instr_waitrequest or data_waitrequest.
- States:
  - RUN
    - freeze: PCWrite=0, IF_ID_Write=0, Pipe_Write=0, all flushes=0. Stay in RUN.
    - else hazard: PCWrite=0, IF_ID_Write=0, ID_EX_Flush=1, Pipe_Write=1. Stay in RUN.
    - else: all writes=1, flushes=0.
    - If RegPC==0 and not freeze: go to DRAIN, load counter=DRAIN_CYCLES-1.
  - DRAIN
    - IF_ID_Flush=1 (fetch from 0 is discarded), ID_EX_Flush=hazard, PCWrite=0, Pipe_Write=!freeze.
    - Counter decrements only on unfrozen cycles. At 0 with !freeze, go to HALTED.
  - HALTED
    - PCWrite=0, IF_ID_Write=0, IF_ID_Flush=1, ID_EX_Flush=1, Pipe_Write=1 (drains bubbles), active=0.
    - Terminal until reset.
- Priority: reset > HALTED > freeze > hazard > normal.
- A freeze during a hazard holds the bubble; the bubble is inserted exactly once, on the unfrozen cycle.
- A load followed by a dependent branch costs exactly 2 bubbles.
- Reset mid-DRAIN or in HALTED returns to RUN next cycle with active=1.

Optional Feature:
- Macro: PIPE_HAZARD_PERF_EN.
- Defined:
  - cycle_count increments on every unfrozen cycle while active=1.
  - stall_cycles increments on every cycle where ID_EX_Flush=1 due to hazard (not reset or HALTED).
  - Both counters saturate at all-ones and clear on reset.
- Undefined: both outputs are tied to 0 and no counter flops exist.

Test Plan:
- lw $2,0($1); add $3,$2,$4: exactly 1 cycle with PCWrite=0, ID_EX_Flush=1, then normal flow; stall_cycles=1.
- lw $2; beq $2,$5: 2 consecutive bubble cycles; addu $2; beq $2,$5: 1 bubble.
- lw $0 followed by a use of $0: no stall, PCWrite stays 1.
- Hazard with instr_waitrequest high for 3 cycles: 3 full-freeze cycles (Pipe_Write=0), then a single bubble; stall_cycles=1.
- jr $ra with $ra=0: RegPC==0 → IF_ID_Flush=1 for 4 unfrozen cycles, then active=0; a data_waitrequest pulse mid-drain extends the drain by its length.
- Reset asserted in HALTED: the next cycle shows active=1, state RUN, counters=0.

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush controller for the 5-stage MIPS pipeline.
// Detects load-use and branch-in-ID operand hazards, freezes the whole pipe on
// Avalon waitrequest, and drains then halts the core once the PC reaches 0.
// Optional performance counters are built when PIPE_HAZARD_PERF_EN is defined.
module pipe_hazard_ctrl #(
  parameter int unsigned DRAIN_CYCLES = 4,
  parameter int unsigned CNT_W        = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      IF_ID_Instruction,
  input  logic [31:0]      RegPC,
  input  logic             ID_EX_MemRead,
  input  logic             ID_EX_RegWrite,
  input  logic [4:0]       ID_EX_WriteReg,
  input  logic             EX_MEM_MemRead,
  input  logic [4:0]       EX_MEM_WriteReg,
  input  logic             instr_waitrequest,
  input  logic             data_waitrequest,
  output logic             PCWrite,
  output logic             IF_ID_Write,
  output logic             IF_ID_Flush,
  output logic             ID_EX_Flush,
  output logic             Pipe_Write,
  output logic             active,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] cycle_count
);

  typedef enum logic [1:0] {StRun, StDrain, StHalted} state_e;

  localparam int unsigned DrainW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [DrainW-1:0] DrainLoad = DrainW'(DRAIN_CYCLES - 1);

  state_e            state_q, state_d;
  logic [DrainW-1:0] drain_q, drain_d;

  logic [5:0] opcode, funct;
  logic [4:0] rs, rt;
  logic       is_jr, uses_rs, uses_rt, branch_id;
  logic       match_ex, match_mem, hazard, freeze, bubble;

  assign opcode = IF_ID_Instruction[31:26];
  assign funct  = IF_ID_Instruction[5:0];
  assign rs     = IF_ID_Instruction[25:21];
  assign rt     = IF_ID_Instruction[20:16];

  // Decode which source registers the ID instruction reads and whether it resolves in ID
  always_comb begin
    is_jr     = (opcode == 6'b000000) && (funct == 6'b001000 || funct == 6'b001001);
    uses_rs   = (opcode != 6'b000010) && (opcode != 6'b000011);
    uses_rt   = ((opcode == 6'b000000) && !is_jr) || (opcode == 6'b000100) ||
                (opcode == 6'b000101) || (opcode[5:3] == 3'b101);
    branch_id = (opcode == 6'b000100) || (opcode == 6'b000101) || (opcode == 6'b000110) ||
                (opcode == 6'b000111) || (opcode == 6'b000001) || is_jr;
  end

  // Register 0 is hard-wired, so it never creates a dependency
  assign match_ex  = (ID_EX_WriteReg != 5'd0) &&
                     ((uses_rs && rs == ID_EX_WriteReg) || (uses_rt && rt == ID_EX_WriteReg));
  assign match_mem = (EX_MEM_WriteReg != 5'd0) &&
                     ((uses_rs && rs == EX_MEM_WriteReg) || (uses_rt && rt == EX_MEM_WriteReg));

  assign hazard = ((ID_EX_MemRead || (branch_id && ID_EX_RegWrite)) && match_ex) ||
                  (branch_id && EX_MEM_MemRead && match_mem);
  assign freeze = instr_waitrequest || data_waitrequest;

  // Next-state and pipeline control outputs
  always_comb begin
    state_d     = state_q;
    drain_d     = drain_q;
    PCWrite     = 1'b0;
    IF_ID_Write = 1'b0;
    IF_ID_Flush = 1'b0;
    ID_EX_Flush = 1'b0;
    Pipe_Write  = 1'b0;
    active      = 1'b0;
    bubble      = 1'b0;
    if (reset) begin
      PCWrite     = 1'b1;
      IF_ID_Write = 1'b1;
      IF_ID_Flush = 1'b1;
      ID_EX_Flush = 1'b1;
      Pipe_Write  = 1'b1;
      state_d     = StRun;
      drain_d     = '0;
    end else begin
      unique case (state_q)
        StRun: begin
          active = 1'b1;
          if (freeze) begin
            // Full freeze: every register holds, a pending bubble waits
          end else if (hazard) begin
            ID_EX_Flush = 1'b1;
            Pipe_Write  = 1'b1;
            bubble      = 1'b1;
          end else begin
            PCWrite     = 1'b1;
            IF_ID_Write = 1'b1;
            Pipe_Write  = 1'b1;
          end
          if (RegPC == 32'd0 && !freeze) begin
            state_d = StDrain;
            drain_d = DrainLoad;
          end
        end
        StDrain: begin
          active      = 1'b1;
          IF_ID_Flush = 1'b1;
          IF_ID_Write = !freeze && !hazard;
          ID_EX_Flush = hazard && !freeze;
          bubble      = hazard && !freeze;
          Pipe_Write  = !freeze;
          if (!freeze) begin
            if (drain_q == '0) begin
              state_d = StHalted;
            end else begin
              drain_d = drain_q - 1'b1;
            end
          end
        end
        StHalted: begin
          IF_ID_Flush = 1'b1;
          ID_EX_Flush = 1'b1;
          Pipe_Write  = 1'b1;
        end
        default: state_d = StRun;
      endcase
    end
  end

  // State and drain counter registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StRun;
      drain_q <= '0;
    end else begin
      state_q <= state_d;
      drain_q <= drain_d;
    end
  end

`ifdef PIPE_HAZARD_PERF_EN
  logic [CNT_W-1:0] stall_q, stall_d, cyc_q, cyc_d;

  // Saturating counter next-state
  always_comb begin
    stall_d = stall_q;
    cyc_d   = cyc_q;
    if (bubble && stall_q != '1) stall_d = stall_q + 1'b1;
    if (active && !freeze && cyc_q != '1) cyc_d = cyc_q + 1'b1;
  end

  // Performance counter registers
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_q <= '0;
      cyc_q   <= '0;
    end else begin
      stall_q <= stall_d;
      cyc_q   <= cyc_d;
    end
  end

  assign stall_cycles = stall_q;
  assign cycle_count  = cyc_q;
`else
  logic unused_bubble;
  assign unused_bubble = bubble;
  assign stall_cycles  = '0;
  assign cycle_count   = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: directed hazard/drain sequences, then random traffic.
module tb_pipe_hazard_ctrl;
  localparam int unsigned DRAIN_CYCLES = 4;
  localparam int unsigned CNT_W        = 32;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic [31:0]      IF_ID_Instruction = '0;
  logic [31:0]      RegPC = 32'h400;
  logic             ID_EX_MemRead = 1'b0, ID_EX_RegWrite = 1'b0;
  logic [4:0]       ID_EX_WriteReg = '0, EX_MEM_WriteReg = '0;
  logic             EX_MEM_MemRead = 1'b0;
  logic             instr_waitrequest = 1'b0, data_waitrequest = 1'b0;
  logic             PCWrite, IF_ID_Write, IF_ID_Flush, ID_EX_Flush, Pipe_Write, active;
  logic [CNT_W-1:0] stall_cycles, cycle_count;

  pipe_hazard_ctrl #(.DRAIN_CYCLES(DRAIN_CYCLES), .CNT_W(CNT_W)) dut (
    .clk               (clk),
    .reset             (reset),
    .IF_ID_Instruction (IF_ID_Instruction),
    .RegPC             (RegPC),
    .ID_EX_MemRead     (ID_EX_MemRead),
    .ID_EX_RegWrite    (ID_EX_RegWrite),
    .ID_EX_WriteReg    (ID_EX_WriteReg),
    .EX_MEM_MemRead    (EX_MEM_MemRead),
    .EX_MEM_WriteReg   (EX_MEM_WriteReg),
    .instr_waitrequest (instr_waitrequest),
    .data_waitrequest  (data_waitrequest),
    .PCWrite           (PCWrite),
    .IF_ID_Write       (IF_ID_Write),
    .IF_ID_Flush       (IF_ID_Flush),
    .ID_EX_Flush       (ID_EX_Flush),
    .Pipe_Write        (Pipe_Write),
    .active            (active),
    .stall_cycles      (stall_cycles),
    .cycle_count       (cycle_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [5:0]       ctl;   // PCWrite, IF_ID_Write, IF_ID_Flush, ID_EX_Flush, Pipe_Write, active
    logic [CNT_W-1:0] stall;
    logic [CNT_W-1:0] cyc;
  } exp_t;

  exp_t sb[$];
  int   vectors = 0;
  int   miscompares = 0;

  // Reference model: -1 running, >0 unfrozen drain cycles left, 0 halted
  int     drain_left = -1;
  longint stall_m = 0, cyc_m = 0;
  longint cnt_max = (longint'(1) << CNT_W) - 1;

  function automatic bit reads_reg(logic [31:0] ins, logic [4:0] r);
    logic [5:0] op, fn;
    bit jr, u_rs, u_rt;
    op   = ins[31:26];
    fn   = ins[5:0];
    jr   = (op == 0) && (fn == 8 || fn == 9);
    u_rs = !(op == 2 || op == 3);
    u_rt = (op == 0 && !jr) || op == 4 || op == 5 || op[5:3] == 3'b101;
    if (r == 0) return 1'b0;
    return (u_rs && ins[25:21] == r) || (u_rt && ins[20:16] == r);
  endfunction

  function automatic bit is_branch(logic [31:0] ins);
    logic [5:0] op, fn;
    op = ins[31:26];
    fn = ins[5:0];
    return op == 1 || (op >= 4 && op <= 7) || (op == 0 && (fn == 8 || fn == 9));
  endfunction

  // Drive one cycle of inputs, predict outputs for it, then advance the model
  task automatic apply(input bit rst, input logic [31:0] ins, input logic [31:0] pc,
                       input bit idmr, input bit idrw, input logic [4:0] idwr,
                       input bit exmr, input logic [4:0] exwr, input bit iw, input bit dw);
    exp_t e;
    bit hz, frz, br;
    @(posedge clk);
    #1;
    reset = rst; IF_ID_Instruction = ins; RegPC = pc;
    ID_EX_MemRead = idmr; ID_EX_RegWrite = idrw; ID_EX_WriteReg = idwr;
    EX_MEM_MemRead = exmr; EX_MEM_WriteReg = exwr;
    instr_waitrequest = iw; data_waitrequest = dw;
    br  = is_branch(ins);
    hz  = ((idmr || (br && idrw)) && reads_reg(ins, idwr)) || (br && exmr && reads_reg(ins, exwr));
    frz = iw || dw;
`ifdef PIPE_HAZARD_PERF_EN
    e.stall = CNT_W'(stall_m);
    e.cyc   = CNT_W'(cyc_m);
`else
    e.stall = '0;
    e.cyc   = '0;
`endif
    if (rst) begin
      e.ctl = 6'b111110;
      drain_left = -1; stall_m = 0; cyc_m = 0;
    end else if (drain_left == 0) begin
      e.ctl = 6'b001110;
    end else if (drain_left < 0) begin
      if (frz)     e.ctl = 6'b000001;
      else if (hz) e.ctl = 6'b000111;
      else         e.ctl = 6'b110011;
      if (!frz && hz && stall_m < cnt_max) stall_m++;
      if (!frz && cyc_m < cnt_max) cyc_m++;
      if (pc == 0 && !frz) drain_left = DRAIN_CYCLES;
    end else begin
      e.ctl = {1'b0, !frz && !hz, 1'b1, hz && !frz, !frz, 1'b1};
      if (!frz && hz && stall_m < cnt_max) stall_m++;
      if (!frz && cyc_m < cnt_max) cyc_m++;
      if (!frz) drain_left--;
    end
    sb.push_back(e);
  endtask

  task automatic norm(input logic [31:0] ins, input logic [31:0] pc, input bit iw, input bit dw);
    apply(1'b0, ins, pc, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, iw, dw);
  endtask

  function automatic logic [31:0] rand_ins();
    logic [5:0] ops [12];
    logic [5:0] fns [4];
    logic [5:0] op;
    ops = '{6'h00, 6'h00, 6'h02, 6'h03, 6'h04, 6'h05, 6'h06, 6'h07, 6'h01, 6'h23, 6'h2b, 6'h08};
    fns = '{6'h20, 6'h08, 6'h09, 6'h2a};
    op  = ops[$urandom_range(0, 11)];
    return {op, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 10'($urandom),
            fns[$urandom_range(0, 3)]};
  endfunction

  task automatic check(input string name, input logic [CNT_W-1:0] act, input logic [CNT_W-1:0] req);
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Monitor: every cycle presents a full control word, compare against the oldest prediction
  always @(negedge clk) begin
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      vectors++;
      check("PCWrite",      CNT_W'(PCWrite),     CNT_W'(e.ctl[5]));
      check("IF_ID_Write",  CNT_W'(IF_ID_Write), CNT_W'(e.ctl[4]));
      check("IF_ID_Flush",  CNT_W'(IF_ID_Flush), CNT_W'(e.ctl[3]));
      check("ID_EX_Flush",  CNT_W'(ID_EX_Flush), CNT_W'(e.ctl[2]));
      check("Pipe_Write",   CNT_W'(Pipe_Write),  CNT_W'(e.ctl[1]));
      check("active",       CNT_W'(active),      CNT_W'(e.ctl[0]));
      check("stall_cycles", stall_cycles,        e.stall);
      check("cycle_count",  cycle_count,         e.cyc);
    end
  end

  localparam logic [31:0] AddDep = 32'h00441820;  // add $3,$2,$4
  localparam logic [31:0] BeqDep = 32'h10450000;  // beq $2,$5
  localparam logic [31:0] AddR0  = 32'h00001820;  // add $3,$0,$0
  localparam logic [31:0] JrRa   = 32'h03E00008;  // jr $ra

  initial begin
    int guard;
    apply(1'b1, 32'h0, 32'h400, 0, 0, 5'd0, 0, 5'd0, 0, 0);
    apply(1'b1, 32'h0, 32'h400, 0, 0, 5'd0, 0, 5'd0, 0, 0);
    norm(AddDep, 32'h404, 0, 0);
    // lw $2 ; add uses $2: one bubble
    apply(1'b0, AddDep, 32'h408, 1, 1, 5'd2, 0, 5'd0, 0, 0);
    apply(1'b0, AddDep, 32'h408, 0, 0, 5'd0, 1, 5'd2, 0, 0);
    // lw $2 ; beq $2: two bubbles
    apply(1'b0, BeqDep, 32'h40c, 1, 1, 5'd2, 0, 5'd0, 0, 0);
    apply(1'b0, BeqDep, 32'h40c, 0, 0, 5'd0, 1, 5'd2, 0, 0);
    apply(1'b0, BeqDep, 32'h40c, 0, 0, 5'd0, 0, 5'd0, 0, 0);
    // addu $2 ; beq $2: one bubble
    apply(1'b0, BeqDep, 32'h410, 0, 1, 5'd2, 0, 5'd0, 0, 0);
    apply(1'b0, BeqDep, 32'h410, 0, 0, 5'd0, 0, 5'd2, 0, 0);
    // lw $0 ; use $0: no stall
    apply(1'b0, AddR0, 32'h414, 1, 1, 5'd0, 1, 5'd0, 0, 0);
    // Hazard under a 3-cycle instruction freeze, then a single bubble
    for (int i = 0; i < 3; i++) apply(1'b0, AddDep, 32'h418, 1, 1, 5'd2, 0, 5'd0, 1, 0);
    apply(1'b0, AddDep, 32'h418, 1, 1, 5'd2, 0, 5'd0, 0, 0);
    apply(1'b0, AddDep, 32'h418, 0, 0, 5'd0, 1, 5'd2, 0, 0);
    // jr $ra with $ra=0: drain with a 2-cycle data stall in the middle, then halt
    norm(JrRa, 32'h0, 0, 0);
    norm(32'h0, 32'h0, 0, 0);
    norm(32'h0, 32'h0, 0, 1);
    norm(32'h0, 32'h0, 0, 1);
    for (int i = 0; i < 6; i++) norm(32'h0, 32'h0, 0, 0);
    // Reset from HALTED
    apply(1'b1, 32'h0, 32'h400, 0, 0, 5'd0, 0, 5'd0, 0, 0);
    norm(AddDep, 32'h404, 0, 0);
    norm(AddDep, 32'h408, 0, 0);
    // Random traffic
    for (int n = 0; n < 3000; n++) begin
      apply($urandom_range(0, 79) == 0, rand_ins(),
            ($urandom_range(0, 29) == 0) ? 32'h0 : 32'h400 + 32'($urandom_range(1, 255)) * 4,
            $urandom_range(0, 2) == 0, $urandom_range(0, 1) == 0, 5'($urandom_range(0, 3)),
            $urandom_range(0, 2) == 0, 5'($urandom_range(0, 3)),
            $urandom_range(0, 5) == 0, $urandom_range(0, 7) == 0);
    end
    guard = 0;
    while (sb.size() > 0 && guard < 5) begin
      @(posedge clk);
      guard++;
    end
    if (sb.size() > 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain: %0d entries left, required 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
